cv32e40p_wb_port_arbiter: RTL and testbench
===========================================

Name: cv32e40p_wb_port_arbiter

Overview:
- Arbitrates the EX-stage ALU/forwarding register-file write port between two sources: in-order EX results (ALU/MULT/CSR/string-op) and out-of-order coprocessor (APU) result returns.
- Coprocessor results cannot be back-pressured. Any result that loses arbitration is parked in a small skid FIFO.
- An age limit ensures parked results cannot starve; when it forces a drain, the EX stage is stalled.
- Sits between the EX result mux and the ID-stage forwarding/regfile write inputs.

Parameters:
- DEPTH, 2, number of skid FIFO entries (power of two, at least 2).
- MAX_WAIT, 3, cycles a FIFO head may lose to EX before it is forced out (at least 1).
- ADDR_W, 6, register address width (includes the FP register bank bit).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- ex_we_i  in  1  EX stage requests a write this cycle.
- ex_waddr_i  in  ADDR_W  EX write address.
- ex_wdata_i  in  32  EX write data.
- cop_rvalid_i  in  1  coprocessor result valid (one-cycle pulse, cannot be stalled).
- cop_waddr_i  in  ADDR_W  coprocessor destination register.
- cop_result_i  in  32  coprocessor result.
- rs_addr_i  in  3xADDR_W  ID-stage source register addresses for the hazard check.
- rs_valid_i  in  3  per-address valid.
- wp_we_o  out  1  write-port enable.
- wp_waddr_o  out  ADDR_W  write-port address.
- wp_wdata_o  out  32  write-port data.
- ex_stall_o  out  1  EX write blocked this cycle; EX must hold.
- cop_full_o  out  1  FIFO holds DEPTH entries; the dispatcher must not issue new coprocessor ops.
- dep_o  out  1  a valid rs address matches a parked FIFO entry.
- busy_o  out  1  FIFO non-empty.
- overflow_o  out  1  sticky: a coprocessor result was dropped.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- State: FIFO storage (waddr, data), read/write pointers, count (0..DEPTH), head age counter, overflow flag.
- Reset state: count=0, pointers=0, age=0, overflow_o=0.
  - With the FIFO empty, the outputs reduce to: wp_* selects EX (or bypassed coprocessor result) per the priority below.
  - ex_stall_o=0, cop_full_o=0, busy_o=0, dep_o=0.
- Outputs wp_*, ex_stall_o and dep_o are combinational from current state and inputs. All state updates occur on posedge clk.
- Define head_v = (count != 0) and force = head_v & (age >= MAX_WAIT | count == DEPTH).
- Per-cycle priority:
  1. force: port drives the FIFO head and pops it; ex_stall_o = ex_we_i.
  2. else ex_we_i: port drives EX; no pop; ex_stall_o=0.
  3. else head_v: port drives the FIFO head and pops it.
  4. else cop_rvalid_i: port drives cop_* directly (bypass, zero latency); no push.
  5. else wp_we_o=0, wp_waddr_o=0, wp_wdata_o=0.
- Push: cop_rvalid_i and the result was not bypassed. The entry is written at the tail.
  - Pop and push in the same cycle are both performed; count is unchanged, including when count==DEPTH.
- Overflow: push requested while count==DEPTH and no pop this cycle.
  - The result is dropped, overflow_o is set, and it holds until reset.
  - Pointers and count are unchanged.
- FIFO ordering: strictly in order. The head is always the oldest result, and no two parked results are reordered.
- Age:
  - Cleared to 0 on any pop, and whenever count is 0.
  - Otherwise increments by 1 each cycle the head remains unpopped.
  - Saturates at MAX_WAIT.
  - After a pop, the new head starts at age 0.
- ex_stall_o is asserted only in case 1 with ex_we_i=1. The EX stage holds its result and retries the next cycle.
- cop_full_o = (count == DEPTH), registered-state based.
- dep_o: OR over i in 0..2 of rs_valid_i[i] & (rs_addr_i[i] matches the waddr of any valid FIFO entry). A bypassed or in-flight cop result does not contribute.
- Pointers wrap modulo DEPTH.
- busy_o = head_v.
- Reset asserted mid-operation empties the FIFO immediately (asynchronously); parked results are discarded.

Test Plan:
- Idle bypass: FIFO empty, ex_we_i=0, cop_rvalid_i=1, waddr=5, data=0xDEADBEEF → same cycle wp_we_o=1, waddr=5, wdata=0xDEADBEEF; busy_o stays 0.
- Collision park: ex_we_i=1 (waddr=3, data=0x11) with cop_rvalid_i=1 (waddr=7, data=0x22) → port drives 3/0x11. Next cycle busy_o=1 and dep_o=1 for rs_addr=7. When EX is idle the next cycle, the port drives 7/0x22 and busy_o then drops.
- Starvation: park one entry, then hold ex_we_i=1 continuously with MAX_WAIT=3 → EX wins for 3 cycles; on the 4th cycle the port drives the FIFO entry and ex_stall_o=1. The following cycle EX wins again.
- Full forces drain: DEPTH=2, fill with two parked results while EX writes each cycle → cop_full_o=1, next cycle head forced out, ex_stall_o=1. A cop_rvalid_i in that same cycle is pushed, count stays 2, no overflow.
- Overflow: count=2 and the drain is not taken (assert reset-free corner by holding force and verifying pop precedence; then inject a push with no pop via a model that forces state) → overflow_o=1 sticky, entries unchanged. Also check in-order retirement of 0xA then 0xB.
- Reset mid-operation: FIFO holding 2 entries, deassert rst_n asynchronously → busy_o, cop_full_o and overflow_o go to 0 immediately. After release, a bypass transaction works normally.

Source files
------------

// File: rtl/cv32e40p_wb_port_arbiter.sv
// Purpose     : shares the EX-stage register-file write port between in-order EX
//               results and unstallable coprocessor (APU) result returns.
// Latency     : zero-cycle bypass when the port is free; a parked result retires
//               in order once EX is idle or its age limit forces it out.
// Backpressure: coprocessor results are never stalled; losers park in a skid FIFO.
//               A forced drain stalls EX (ex_stall_o). cop_full_o asks the
//               dispatcher to stop issuing.
//
// Ports:
//   clk, rst_n                       core clock, async active-low reset
//   ex_we_i/ex_waddr_i/ex_wdata_i    in-order EX write request
//   cop_rvalid_i/cop_waddr_i/
//   cop_result_i                     coprocessor result pulse
//   rs_addr_i/rs_valid_i             ID-stage source operands (3 slots)
//   wp_we_o/wp_waddr_o/wp_wdata_o    register-file write port
//   ex_stall_o                       EX must hold its result this cycle
//   cop_full_o                       skid FIFO full
//   dep_o                            an ID source matches a parked result
//   busy_o                           skid FIFO non-empty
//   overflow_o                       sticky: a coprocessor result was dropped
module cv32e40p_wb_port_arbiter #(
   parameter int DEPTH    = 2,
   parameter int MAX_WAIT = 3,
   parameter int ADDR_W   = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ex_we_i,
   input  logic [ADDR_W-1:0]     ex_waddr_i,
   input  logic [31:0]           ex_wdata_i,
   input  logic                  cop_rvalid_i,
   input  logic [ADDR_W-1:0]     cop_waddr_i,
   input  logic [31:0]           cop_result_i,
   input  logic [3*ADDR_W-1:0]   rs_addr_i,
   input  logic [2:0]            rs_valid_i,
   output logic                  wp_we_o,
   output logic [ADDR_W-1:0]     wp_waddr_o,
   output logic [31:0]           wp_wdata_o,
   output logic                  ex_stall_o,
   output logic                  cop_full_o,
   output logic                  dep_o,
   output logic                  busy_o,
   output logic                  overflow_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int AW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [AW-1:0] MAXW_C  = AW'(MAX_WAIT);

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_EX,
      SRC_HEAD,
      SRC_COP
   } src_e;

   // Skid FIFO storage and bookkeeping
   logic [ADDR_W-1:0] mem_addr [DEPTH];
   logic [31:0]       mem_data [DEPTH];
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic [CW-1:0]     count;
   logic [AW-1:0]     age;
   logic              overflow;

   logic head_v;
   logic full;
   logic force_drain;
   src_e src;
   logic pop;
   logic push_req;
   logic push_ok;
   logic ovf_evt;

   assign head_v = (count != '0);
   assign full   = (count == DEPTH_C);
   // A full FIFO must drain now: the next coprocessor return cannot be refused.
   assign force_drain = head_v & ((age >= MAXW_C) | full);

   // Port source selection, highest priority first
   always_comb begin
      src        = SRC_NONE;
      pop        = 1'b0;
      ex_stall_o = 1'b0;
      if (force_drain) begin
         src        = SRC_HEAD;
         pop        = 1'b1;
         ex_stall_o = ex_we_i;
      end else if (ex_we_i) begin
         src = SRC_EX;
      end else if (head_v) begin
         src = SRC_HEAD;
         pop = 1'b1;
      end else if (cop_rvalid_i) begin
         src = SRC_COP;
      end
   end

   // Any coprocessor result that did not take the port directly is parked.
   // When full, the same-cycle pop frees the slot being written.
   assign push_req = cop_rvalid_i & (src != SRC_COP);
   assign push_ok  = push_req & (~full | pop);
   assign ovf_evt  = push_req & full & ~pop;

   always_comb begin
      wp_we_o    = 1'b0;
      wp_waddr_o = '0;
      wp_wdata_o = '0;
      case (src)
         SRC_EX: begin
            wp_we_o    = 1'b1;
            wp_waddr_o = ex_waddr_i;
            wp_wdata_o = ex_wdata_i;
         end
         SRC_HEAD: begin
            wp_we_o    = 1'b1;
            wp_waddr_o = mem_addr[rd_ptr];
            wp_wdata_o = mem_data[rd_ptr];
         end
         SRC_COP: begin
            wp_we_o    = 1'b1;
            wp_waddr_o = cop_waddr_i;
            wp_wdata_o = cop_result_i;
         end
         default: begin
            wp_we_o = 1'b0;
         end
      endcase
   end

   // Hazard check against parked entries only; a slot is live when its
   // distance from the head is below the occupancy.
   always_comb begin
      dep_o = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
         logic [PW-1:0] offs;
         logic          live;
         offs = PW'(j) - rd_ptr;
         live = ({1'b0, offs} < count);
         for (int i = 0; i < 3; i++) begin
            if (live && rs_valid_i[i] &&
                (rs_addr_i[i*ADDR_W +: ADDR_W] == mem_addr[j])) begin
               dep_o = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         age      <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push_ok, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         // Age tracks the current head only; a new head starts fresh.
         if (pop || !head_v) begin
            age <= '0;
         end else if (age != MAXW_C) begin
            age <= age + AW'(1);
         end
         if (ovf_evt) begin
            overflow <= 1'b1;
         end
      end
   end

   // Payload storage needs no reset: occupancy decides what is live.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_addr[wr_ptr] <= cop_waddr_i;
         mem_data[wr_ptr] <= cop_result_i;
      end
   end

   assign cop_full_o = full;
   assign busy_o     = head_v;
   assign overflow_o = overflow;

endmodule

// File: tb/tb_cv32e40p_wb_port_arbiter.sv
// Bench for cv32e40p_wb_port_arbiter (DEPTH=2, MAX_WAIT=3, ADDR_W=6).
// Per-cycle vector table with expected port source and flags; coprocessor
// results go to an in-order scoreboard and are popped when the port retires them.
module tb_cv32e40p_wb_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic        ex_we;
   logic [5:0]  ex_waddr;
   logic [31:0] ex_wdata;
   logic        cop_rvalid;
   logic [5:0]  cop_waddr;
   logic [31:0] cop_result;
   logic [17:0] rs_addr;
   logic [2:0]  rs_valid;
   logic        wp_we;
   logic [5:0]  wp_waddr;
   logic [31:0] wp_wdata;
   logic        ex_stall;
   logic        cop_full;
   logic        dep;
   logic        busy;
   logic        overflow;

   int n_cmp;
   int n_fail;

   cv32e40p_wb_port_arbiter #(.DEPTH(2), .MAX_WAIT(3), .ADDR_W(6)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ex_we_i      (ex_we),
      .ex_waddr_i   (ex_waddr),
      .ex_wdata_i   (ex_wdata),
      .cop_rvalid_i (cop_rvalid),
      .cop_waddr_i  (cop_waddr),
      .cop_result_i (cop_result),
      .rs_addr_i    (rs_addr),
      .rs_valid_i   (rs_valid),
      .wp_we_o      (wp_we),
      .wp_waddr_o   (wp_waddr),
      .wp_wdata_o   (wp_wdata),
      .ex_stall_o   (ex_stall),
      .cop_full_o   (cop_full),
      .dep_o        (dep),
      .busy_o       (busy),
      .overflow_o   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // src: 0 = port idle, 1 = EX inputs, 2 = oldest scoreboard entry
   typedef struct {
      logic        ex_we;
      logic [5:0]  ex_a;
      logic [31:0] ex_d;
      logic        cv;
      logic [5:0]  ca;
      logic [31:0] cd;
      logic        rsv;
      int          rs_idx;
      logic [5:0]  rs;
      int          src;
      logic        stall;
      logic        full;
      logic        dep;
      logic        busy;
      logic        ovf;
   } vec_t;

   typedef struct {
      logic [5:0]  a;
      logic [31:0] d;
   } wr_t;

   vec_t vecs[$];
   wr_t  sb[$];

   function automatic vec_t mk(logic exw, logic [5:0] exa, logic [31:0] exd,
                               logic cv, logic [5:0] ca, logic [31:0] cd,
                               logic rsv, int rsi, logic [5:0] rs, int src,
                               logic st, logic fu, logic dp, logic bz, logic ov);
      vec_t v;
      v.ex_we = exw; v.ex_a = exa; v.ex_d = exd;
      v.cv = cv; v.ca = ca; v.cd = cd;
      v.rsv = rsv; v.rs_idx = rsi; v.rs = rs; v.src = src;
      v.stall = st; v.full = fu; v.dep = dp; v.busy = bz; v.ovf = ov;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      ex_we = 1'b0; ex_waddr = '0; ex_wdata = '0;
      cop_rvalid = 1'b0; cop_waddr = '0; cop_result = '0;
      rs_addr = '0; rs_valid = '0;
   endtask

   // Checks the port against the expected source; cop results come off the scoreboard.
   task automatic chk_port(input string nm, input int src);
      wr_t w;
      if (src == 0) begin
         chk({nm, ".we"}, 32'(wp_we), 32'd0);
         chk({nm, ".addr"}, 32'(wp_waddr), 32'd0);
         chk({nm, ".data"}, wp_wdata, 32'd0);
      end else if (src == 1) begin
         chk({nm, ".we"}, 32'(wp_we), 32'd1);
         chk({nm, ".addr"}, 32'(wp_waddr), 32'(ex_waddr));
         chk({nm, ".data"}, wp_wdata, ex_wdata);
      end else begin
         chk({nm, ".we"}, 32'(wp_we), 32'd1);
         if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s.sb: port wrote 0x%0h but no coprocessor result outstanding",
                     nm, wp_wdata);
         end else begin
            w = sb.pop_front();
            chk({nm, ".addr"}, 32'(wp_waddr), 32'(w.a));
            chk({nm, ".data"}, wp_wdata, w.d);
         end
      end
   endtask

   task automatic apply(input vec_t v, input int row);
      string nm;
      nm = $sformatf("row%0d", row);
      @(negedge clk);
      ex_we = v.ex_we; ex_waddr = v.ex_a; ex_wdata = v.ex_d;
      cop_rvalid = v.cv; cop_waddr = v.ca; cop_result = v.cd;
      rs_addr = '0;
      rs_addr[v.rs_idx*6 +: 6] = v.rs;
      rs_valid = 3'(v.rsv) << v.rs_idx;
      if (v.cv) sb.push_back('{a: v.ca, d: v.cd});
      #3;
      chk_port(nm, v.src);
      chk({nm, ".stall"}, 32'(ex_stall), 32'(v.stall));
      chk({nm, ".full"}, 32'(cop_full), 32'(v.full));
      chk({nm, ".dep"}, 32'(dep), 32'(v.dep));
      chk({nm, ".busy"}, 32'(busy), 32'(v.busy));
      chk({nm, ".ovf"}, 32'(overflow), 32'(v.ovf));
   endtask

   initial begin
      n_cmp = 0;
      n_fail = 0;
      idle_inputs();
      rst_n = 1'b0;

      // ex_we exa exd   cv ca cd   rsv idx rs  src  stall full dep busy ovf
      vecs.push_back(mk(0, 0, 0,        0, 0, 0,            0, 0, 0,  0, 0, 0, 0, 0, 0)); // idle
      vecs.push_back(mk(0, 0, 0,        1, 5, 32'hDEADBEEF, 0, 0, 0,  2, 0, 0, 0, 0, 0)); // bypass
      vecs.push_back(mk(1, 3, 32'h11,   1, 7, 32'h22,       1, 0, 7,  1, 0, 0, 0, 0, 0)); // collision
      vecs.push_back(mk(0, 0, 0,        0, 0, 0,            1, 1, 7,  2, 0, 0, 1, 1, 0)); // drain parked
      vecs.push_back(mk(0, 0, 0,        0, 0, 0,            1, 1, 7,  0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 32'h100,  1, 9, 32'hA,        0, 0, 0,  1, 0, 0, 0, 0, 0)); // starvation
      vecs.push_back(mk(1, 2, 32'h101,  0, 0, 0,            1, 2, 9,  1, 0, 0, 1, 1, 0));
      vecs.push_back(mk(1, 4, 32'h102,  0, 0, 0,            0, 0, 0,  1, 0, 0, 0, 1, 0));
      vecs.push_back(mk(1, 4, 32'h103,  0, 0, 0,            0, 0, 0,  1, 0, 0, 0, 1, 0));
      vecs.push_back(mk(1, 6, 32'h104,  0, 0, 0,            1, 0, 9,  2, 1, 0, 1, 1, 0)); // forced
      vecs.push_back(mk(1, 6, 32'h104,  0, 0, 0,            1, 0, 9,  1, 0, 0, 0, 0, 0)); // EX retry
      vecs.push_back(mk(1, 1, 32'h200,  1, 10, 32'hB0,      0, 0, 0,  1, 0, 0, 0, 0, 0)); // fill
      vecs.push_back(mk(1, 2, 32'h201,  1, 11, 32'hB1,      1, 0, 10, 1, 0, 0, 1, 1, 0));
      vecs.push_back(mk(1, 3, 32'h202,  1, 12, 32'hB2,      1, 1, 11, 2, 1, 1, 1, 1, 0)); // full: pop+push
      vecs.push_back(mk(1, 3, 32'h202,  0, 0, 0,            1, 2, 10, 2, 1, 1, 0, 1, 0)); // still full
      vecs.push_back(mk(1, 3, 32'h202,  0, 0, 0,            1, 0, 12, 1, 0, 0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0,        0, 0, 0,            0, 0, 0,  2, 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0,        0, 0, 0,            0, 0, 0,  0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 32'h1,    1, 20, 32'hA,       0, 0, 0,  1, 0, 0, 0, 0, 0)); // order A,B
      vecs.push_back(mk(1, 2, 32'h2,    1, 21, 32'hB,       0, 0, 0,  1, 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0,        0, 0, 0,            0, 0, 0,  2, 0, 1, 0, 1, 0)); // full, EX idle
      vecs.push_back(mk(0, 0, 0,        1, 22, 32'hC,       1, 0, 22, 2, 0, 0, 0, 1, 0)); // pop+push
      vecs.push_back(mk(0, 0, 0,        0, 0, 0,            1, 0, 22, 2, 0, 0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0,        0, 0, 0,            0, 0, 0,  0, 0, 0, 0, 0, 0));

      // Reset state
      #1;
      chk_port("reset", 0);
      chk("reset.stall", 32'(ex_stall), 32'd0);
      chk("reset.full", 32'(cop_full), 32'd0);
      chk("reset.dep", 32'(dep), 32'd0);
      chk("reset.busy", 32'(busy), 32'd0);
      chk("reset.ovf", 32'(overflow), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int r = 0; r < vecs.size(); r++) begin
         apply(vecs[r], r);
      end

      // Asynchronous reset with two parked results
      @(negedge clk);
      ex_we = 1'b1; ex_waddr = 6'd1; ex_wdata = 32'h300;
      cop_rvalid = 1'b1; cop_waddr = 6'd30; cop_result = 32'hD0;
      @(negedge clk);
      ex_wdata = 32'h301; cop_waddr = 6'd31; cop_result = 32'hD1;
      @(negedge clk);
      idle_inputs();
      #1;
      chk("prerst.busy", 32'(busy), 32'd1);
      chk("prerst.full", 32'(cop_full), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst.busy", 32'(busy), 32'd0);
      chk("arst.full", 32'(cop_full), 32'd0);
      chk("arst.ovf", 32'(overflow), 32'd0);
      chk("arst.we", 32'(wp_we), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Bypass after reset release
      @(negedge clk);
      cop_rvalid = 1'b1; cop_waddr = 6'd40; cop_result = 32'h1234;
      #3;
      chk("postrst.we", 32'(wp_we), 32'd1);
      chk("postrst.addr", 32'(wp_waddr), 32'd40);
      chk("postrst.data", wp_wdata, 32'h1234);
      chk("postrst.busy", 32'(busy), 32'd0);
      @(negedge clk);
      idle_inputs();
      #3;
      chk("postrst.idle_busy", 32'(busy), 32'd0);
      chk("sb.empty", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
